// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared Brent-Kung word width, word type and prefix level count
package bk_pkg;
  localparam int BK_WIDTH = 16;
  typedef logic [BK_WIDTH-1:0] bk_word_t;
  localparam int BK_LEVELS = $clog2(BK_WIDTH);
endpackage

// File: rtl/bk_prefix_cell.sv
// rtl/bk_prefix_cell.sv - combinational (G,P) black cell; grey use leaves p_o unread
module bk_prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi | (p_hi & g_lo);
  assign p_o = p_hi & p_lo;
endmodule

// File: rtl/bk_subtractor_pipe.sv
// rtl/bk_subtractor_pipe.sv - two-stage Brent-Kung subtractor with valid/ready on both sides
// Optional signed-overflow output enabled by defining BK_SUB_OVF_EN.
module bk_subtractor_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH = BK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef BK_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic     v1, v2, s1_load, s2_load;
  bk_word_t bb, g, p;
  logic [7:0] g_even, l1_g, l1_p;
  logic [3:0] l2_g, l2_p;

  assign s2_load   = !v2 || out_ready;
  assign s1_load   = !v1 || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2;

  // Carry-in of 1 is folded into bit 0, so the prefix G over [i:0] is the carry into bit i+1.
  assign bb = ~b;
  assign p  = a ^ bb;
  assign g  = {a[15:1] & bb[15:1], a[0] | bb[0]};

  genvar k;
  for (k = 0; k < 8; k++) begin : g_l1
    assign g_even[k] = g[2*k];
    bk_prefix_cell u_cell (.g_hi(g[2*k+1]), .p_hi(p[2*k+1]), .g_lo(g[2*k]), .p_lo(p[2*k]),
                           .g_o(l1_g[k]), .p_o(l1_p[k]));
  end
  for (k = 0; k < 4; k++) begin : g_l2
    bk_prefix_cell u_cell (.g_hi(l1_g[2*k+1]), .p_hi(l1_p[2*k+1]), .g_lo(l1_g[2*k]),
                           .p_lo(l1_p[2*k]), .g_o(l2_g[k]), .p_o(l2_p[k]));
  end

  bk_word_t   s1_p;
  logic [7:0] s1_ge, s1_l1g, s1_l1p;
  logic [3:0] s1_l2g, s1_l2p;
`ifdef BK_SUB_OVF_EN
  logic       s1_sa, s1_sb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (s1_load) v1 <= in_valid;
      if (s2_load) v2 <= v1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p   <= '0;
      s1_ge  <= '0;
      s1_l1g <= '0;
      s1_l1p <= '0;
      s1_l2g <= '0;
      s1_l2p <= '0;
`ifdef BK_SUB_OVF_EN
      s1_sa  <= 1'b0;
      s1_sb  <= 1'b0;
`endif
    end else if (s1_load && in_valid) begin
      s1_p   <= p;
      s1_ge  <= g_even;
      s1_l1g <= l1_g;
      s1_l1p <= l1_p;
      s1_l2g <= l2_g;
      s1_l2p <= l2_p;
`ifdef BK_SUB_OVF_EN
      s1_sa  <= a[15];
      s1_sb  <= b[15];
`endif
    end
  end

  // Stage 2: up-sweep levels 3-4, then down-sweep fills the remaining carries.
  logic [16:0] c;
  logic [1:0]  l3_g, l3_p;
  logic [10:0] grey_p;
  logic        top_p;
  bk_word_t    sum;

  for (k = 0; k < 2; k++) begin : g_l3
    bk_prefix_cell u_cell (.g_hi(s1_l2g[2*k+1]), .p_hi(s1_l2p[2*k+1]), .g_lo(s1_l2g[2*k]),
                           .p_lo(s1_l2p[2*k]), .g_o(l3_g[k]), .p_o(l3_p[k]));
  end
  bk_prefix_cell u_l4 (.g_hi(l3_g[1]), .p_hi(l3_p[1]), .g_lo(l3_g[0]), .p_lo(l3_p[0]),
                       .g_o(c[16]), .p_o(top_p));

  assign c[0] = 1'b1;
  assign c[1] = s1_ge[0];
  assign c[2] = s1_l1g[0];
  assign c[4] = s1_l2g[0];
  assign c[8] = l3_g[0];

  bk_prefix_cell u_c12 (.g_hi(s1_l2g[2]), .p_hi(s1_l2p[2]), .g_lo(c[8]), .p_lo(1'b0),
                        .g_o(c[12]), .p_o(grey_p[0]));
  bk_prefix_cell u_c6  (.g_hi(s1_l1g[2]), .p_hi(s1_l1p[2]), .g_lo(c[4]), .p_lo(1'b0),
                        .g_o(c[6]), .p_o(grey_p[1]));
  bk_prefix_cell u_c10 (.g_hi(s1_l1g[4]), .p_hi(s1_l1p[4]), .g_lo(c[8]), .p_lo(1'b0),
                        .g_o(c[10]), .p_o(grey_p[2]));
  bk_prefix_cell u_c14 (.g_hi(s1_l1g[6]), .p_hi(s1_l1p[6]), .g_lo(c[12]), .p_lo(1'b0),
                        .g_o(c[14]), .p_o(grey_p[3]));
  for (k = 1; k < 8; k++) begin : g_odd
    bk_prefix_cell u_cell (.g_hi(s1_ge[k]), .p_hi(s1_p[2*k]), .g_lo(c[2*k]), .p_lo(1'b0),
                           .g_o(c[2*k+1]), .p_o(grey_p[k+3]));
  end

  assign sum = s1_p ^ c[15:0];

  logic unused_p;
  assign unused_p = ^{grey_p, top_p, s1_l1g[7], s1_l1g[5], s1_l1g[3], s1_l1g[1],
                      s1_l1p[7], s1_l1p[5], s1_l1p[3], s1_l1p[1], s1_l1p[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
`ifdef BK_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (s2_load && v1) begin
      diff   <= sum;
      borrow <= ~c[16];
`ifdef BK_SUB_OVF_EN
      ovf    <= (s1_sa ^ s1_sb) & (s1_sa ^ sum[15]);
`endif
    end
  end

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// tb/tb_bk_subtractor_pipe.sv - self-checking bench for bk_subtractor_pipe
module tb_bk_subtractor_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, borrow;
  logic [15:0] diff;
`ifdef BK_SUB_OVF_EN
  logic        ovf;
`endif

  bk_subtractor_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow)
`ifdef BK_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, d;
    logic        br, ov;
  } vec_t;
  typedef struct {
    logic [15:0] d;
    logic        br, ov;
  } res_t;

  int   n_vec = 0;
  int   n_bad = 0;
  res_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer subtraction, signed range test for overflow.
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
    res_t r;
    int   u, s;
    u = int'(x) - int'(y);
    s = int'($signed(x)) - int'($signed(y));
    r.d  = u[15:0];
    r.br = (u < 0);
    r.ov = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic check_out(input string name, input res_t e);
    check({name, "_diff"}, 32'(diff), 32'(e.d));
    check({name, "_borrow"}, 32'(borrow), 32'(e.br));
`ifdef BK_SUB_OVF_EN
    check({name, "_ovf"}, 32'(ovf), 32'(e.ov));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[9];
    res_t        e, held;
    logic        stalled;
    logic [15:0] pa[3], pb[3];

    tbl[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
    tbl[1] = '{16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1};
    tbl[6] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    tbl[8] = '{16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1};

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check_out("rst", '{16'h0000, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Single transactions: latency and result values
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("tbl_lat1_valid", 32'(out_valid), 32'(0));
      tick();
      check("tbl_lat2_valid", 32'(out_valid), 32'(1));
      check_out("tbl", '{tbl[i].d, tbl[i].br, tbl[i].ov});
      tick();
    end

    // Back-to-back stream at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; a = 16'(16'hFFFF - i); b = 16'h0001;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (i < 16) check("stream_in_ready", 32'(in_ready), 32'(1));
      if (i >= 2) begin
        check("stream_valid", 32'(out_valid), 32'(1));
        check("stream_diff", 32'(diff), 32'(16'(16'hFFFE - (i - 2))));
        check("stream_borrow", 32'(borrow), 32'(0));
      end
      tick();
    end
    check("stream_empty", 32'(out_valid), 32'(0));

    // Backpressure: two accepted, third refused, outputs held, then ordered drain
    pa = '{16'h0100, 16'h0000, 16'h4000};
    pb = '{16'h0001, 16'h0010, 16'h2000};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = pa[i]; b = pb[i];
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(i < 2 ? 1 : 0));
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_ready", 32'(in_ready), 32'(0));
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check_out("bp_hold", model(pa[0], pb[0]));
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) check("bp_release_ready", 32'(in_ready), 32'(1));
      check("bp_drain_valid", 32'(out_valid), 32'(1));
      check_out("bp_drain", model(pa[i], pb[i]));
      tick();
      in_valid = 1'b0;
    end
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'(0));
    tick();

    // Reset with two results in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h0001; b = 16'h0000;
    tick();
    a = 16'h0002;
    tick();
    in_valid = 1'b0;
    check("rstmid_full", 32'(out_valid), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", 32'(out_valid), 32'(0));
    check_out("rstmid", '{16'h0000, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid_no_spurious", 32'(out_valid), 32'(0));
      tick();
    end
    in_valid = 1'b1; a = 16'h1234; b = 16'h1234;
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'(1));
    check_out("post_rst", '{16'h0000, 1'b0, 1'b0});
    tick();

    // Randomized traffic against the reference queue
    stalled = 1'b0;
    held = '{16'h0000, 1'b0, 1'b0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (stalled) begin
        check("rnd_hold_valid", 32'(out_valid), 32'(1));
        check("rnd_hold_diff", 32'(diff), 32'(held.d));
      end
      if (in_valid && in_ready) q.push_back(model(a, b));
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_unexpected_out", 32'(1), 32'(0));
        else begin
          e = q.pop_front();
          check_out("rnd", e);
        end
      end
      stalled = out_valid && !out_ready;
      held.d  = diff;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) check("rnd_drain_unexpected", 32'(1), 32'(0));
        else begin
          e = q.pop_front();
          check_out("rnd_drain", e);
        end
      end
      tick();
    end
    check("rnd_left_in_queue", 32'(q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
